fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 179 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch control: sequences boot, stalls, branch redirects/flushes
// and debug halt/resume for the PC and IF/ID pipeline registers.
module fetch_ctrl #(
    parameter int unsigned BOOT_CYCLES  = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    input  logic        resume_req,
    output logic        pc_rst,
    output logic        pc_en,
    output logic        branch_sel,
    output logic [31:0] branch_val,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        halted,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [7:0] BOOT_LAST  = 8'(BOOT_CYCLES - 1);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  boot_cnt_q, boot_cnt_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic        do_redirect;
    logic [31:0] redirect_addr;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        boot_cnt_d    = boot_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        pend_valid_d  = pend_valid_q;
        pend_addr_d   = pend_addr_q;
        do_redirect   = 1'b0;
        redirect_addr = branch_target;

        pc_rst     = 1'b0;
        pc_en      = 1'b1;
        branch_sel = 1'b0;
        branch_val = branch_target;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        halted     = 1'b0;

        case (state_q)
            ST_BOOT: begin
                pc_rst     = 1'b1;
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                ifid_flush = 1'b1;
                if (boot_cnt_q >= BOOT_LAST) begin
                    boot_cnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + 8'd1;
                end
            end

            ST_RUN, ST_STALL: begin
                if (branch_taken) begin
                    do_redirect = 1'b1;
                end else if (halt_req) begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    state_d = ST_HALT;
                end else if (stall_req) begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_FLUSH: begin
                if (branch_taken) begin
                    do_redirect = 1'b1;
                end else begin
                    ifid_flush  = 1'b1;
                    flush_cnt_d = flush_cnt_q - 4'd1;
                    if (flush_cnt_q <= 4'd1) begin
                        flush_cnt_d = '0;
                        state_d     = halt_req ? ST_HALT : ST_RUN;
                    end
                end
            end

            ST_HALT: begin
                if (resume_req && !halt_req) begin
                    // A live branch in the resume cycle supersedes the parked one.
                    pend_valid_d = 1'b0;
                    if (branch_taken) begin
                        do_redirect = 1'b1;
                    end else if (pend_valid_q) begin
                        do_redirect   = 1'b1;
                        redirect_addr = pend_addr_q;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    halted  = 1'b1;
                    if (branch_taken) begin
                        pend_addr_d  = branch_target;
                        pend_valid_d = 1'b1;
                    end
                end
            end

            default: begin
                pc_rst     = 1'b1;
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                ifid_flush = 1'b1;
                state_d    = ST_BOOT;
            end
        endcase

        if (do_redirect) begin
            branch_sel  = 1'b1;
            branch_val  = redirect_addr;
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            flush_cnt_d = FLUSH_LOAD;
            state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end

        // Reset overrides every same-cycle request on the outputs as well.
        if (rst) begin
            pc_rst     = 1'b1;
            pc_en      = 1'b0;
            branch_sel = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            halted     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment only; the
        // parked branch address is cleared too so a resume never sees stale data.
        if (rst) begin
            state_q      <= ST_BOOT;
            boot_cnt_q   <= '0;
            flush_cnt_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            boot_cnt_q   <= boot_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: cycle-by-cycle vector table on the default
// configuration plus a short sequence on a BOOT_CYCLES=1/FLUSH_CYCLES=1 instance.
module tb_fetch_ctrl;

    localparam logic [2:0] B = 3'd0, R = 3'd1, S = 3'd2, F = 3'd3, H = 3'd4;

    typedef struct {
        logic        rst, stall, br;
        logic [31:0] tgt;
        logic        halt, resume;
        logic        prst, pen, bsel;
        logic [31:0] bval;
        logic        ien, ifl, hlt;
        logic [2:0]  st;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, stall_req, branch_taken, halt_req, resume_req;
    logic [31:0] branch_target;

    logic        pc_rst, pc_en, branch_sel, ifid_en, ifid_flush, halted;
    logic [31:0] branch_val;
    logic [2:0]  state;

    logic        d1_pc_rst, d1_pc_en, d1_branch_sel, d1_ifid_en, d1_ifid_flush, d1_halted;
    logic [31:0] d1_branch_val;
    logic [2:0]  d1_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt_req(halt_req), .resume_req(resume_req),
        .pc_rst(pc_rst), .pc_en(pc_en), .branch_sel(branch_sel), .branch_val(branch_val),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush), .halted(halted), .state(state)
    );

    fetch_ctrl #(.BOOT_CYCLES(1), .FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt_req(halt_req), .resume_req(resume_req),
        .pc_rst(d1_pc_rst), .pc_en(d1_pc_en), .branch_sel(d1_branch_sel),
        .branch_val(d1_branch_val), .ifid_en(d1_ifid_en), .ifid_flush(d1_ifid_flush),
        .halted(d1_halted), .state(d1_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t v(input logic r, s, b, input logic [31:0] t, input logic h, q,
                               input logic prst, pen, bsel, input logic [31:0] bval,
                               input logic ien, ifl, hlt, input logic [2:0] st);
        vec_t x;
        x.rst = r; x.stall = s; x.br = b; x.tgt = t; x.halt = h; x.resume = q;
        x.prst = prst; x.pen = pen; x.bsel = bsel; x.bval = bval;
        x.ien = ien; x.ifl = ifl; x.hlt = hlt; x.st = st;
        return x;
    endfunction

    task automatic drive(input logic r, s, b, input logic [31:0] t, input logic h, q);
        rst = r; stall_req = s; branch_taken = b; branch_target = t;
        halt_req = h; resume_req = q;
    endtask

    // Advance one clock, then apply the next inputs shortly after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t rows[$];

    initial begin
        //                r  s  b  tgt    h  q   prst pen bsel bval   ien ifl hlt st
        rows.push_back(v(1, 0, 0, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 1, 0, B)); // reset cycle
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 1, 0, B)); // boot 0
        rows.push_back(v(0, 1, 1, 32'h55,  1, 1,  1, 0, 0, 32'h55,  0, 1, 0, B)); // boot ignores inputs
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 1, 0, B));
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 1, 0, B)); // boot 3
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  0, 1, 0, 32'h0,   1, 0, 0, R)); // 6th cycle
        rows.push_back(v(0, 0, 1, 32'h100, 0, 0,  0, 1, 1, 32'h100, 1, 1, 0, R)); // redirect
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  0, 1, 0, 32'h0,   1, 1, 0, F));
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  0, 1, 0, 32'h0,   1, 0, 0, R));
        rows.push_back(v(0, 1, 0, 32'h0,   0, 0,  0, 0, 0, 32'h0,   0, 0, 0, R)); // stall x3
        rows.push_back(v(0, 1, 0, 32'h0,   0, 0,  0, 0, 0, 32'h0,   0, 0, 0, S));
        rows.push_back(v(0, 1, 0, 32'h0,   0, 0,  0, 0, 0, 32'h0,   0, 0, 0, S));
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  0, 1, 0, 32'h0,   1, 0, 0, S)); // release
        rows.push_back(v(0, 1, 0, 32'h0,   0, 0,  0, 0, 0, 32'h0,   0, 0, 0, R));
        rows.push_back(v(0, 1, 1, 32'h300, 0, 0,  0, 1, 1, 32'h300, 1, 1, 0, S)); // branch beats stall
        rows.push_back(v(0, 1, 0, 32'h0,   0, 0,  0, 1, 0, 32'h0,   1, 1, 0, F)); // stall ignored
        rows.push_back(v(0, 0, 0, 32'h0,   1, 0,  0, 0, 0, 32'h0,   0, 0, 0, R)); // halt req
        rows.push_back(v(0, 0, 0, 32'h0,   1, 0,  0, 0, 0, 32'h0,   0, 0, 1, H));
        rows.push_back(v(0, 0, 1, 32'h200, 1, 0,  0, 0, 0, 32'h200, 0, 0, 1, H)); // park 0x200
        rows.push_back(v(0, 0, 0, 32'h0,   1, 1,  0, 0, 0, 32'h0,   0, 0, 1, H)); // resume ignored
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  0, 0, 0, 32'h0,   0, 0, 1, H));
        rows.push_back(v(0, 0, 0, 32'h0,   0, 1,  0, 1, 1, 32'h200, 1, 1, 0, H)); // resume parked
        rows.push_back(v(0, 0, 1, 32'h400, 0, 0,  0, 1, 1, 32'h400, 1, 1, 0, F)); // flush restart
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  0, 1, 0, 32'h0,   1, 1, 0, F));
        rows.push_back(v(0, 0, 0, 32'h0,   1, 0,  0, 0, 0, 32'h0,   0, 0, 0, R));
        rows.push_back(v(0, 0, 0, 32'h0,   0, 1,  0, 1, 0, 32'h0,   1, 0, 0, H)); // resume, none parked
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  0, 1, 0, 32'h0,   1, 0, 0, R));
        rows.push_back(v(0, 0, 0, 32'h0,   1, 0,  0, 0, 0, 32'h0,   0, 0, 0, R));
        rows.push_back(v(0, 0, 1, 32'h600, 1, 0,  0, 0, 0, 32'h600, 0, 0, 1, H));
        rows.push_back(v(0, 0, 1, 32'h700, 0, 1,  0, 1, 1, 32'h700, 1, 1, 0, H)); // live beats parked
        rows.push_back(v(1, 0, 1, 32'h800, 0, 0,  1, 0, 0, 32'h800, 0, 1, 0, F)); // rst in flush
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 1, 0, B));
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 1, 0, B));
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 1, 0, B));
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 1, 0, B));
        rows.push_back(v(0, 0, 0, 32'h0,   1, 0,  0, 0, 0, 32'h0,   0, 0, 0, R));
        rows.push_back(v(0, 0, 0, 32'h0,   0, 1,  0, 1, 0, 32'h0,   1, 0, 0, H)); // nothing parked
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  0, 1, 0, 32'h0,   1, 0, 0, R));
        rows.push_back(v(0, 0, 0, 32'h0,   1, 0,  0, 0, 0, 32'h0,   0, 0, 0, R));
        rows.push_back(v(0, 0, 1, 32'hA,   1, 0,  0, 0, 0, 32'hA,   0, 0, 1, H));
        rows.push_back(v(0, 0, 1, 32'hB,   1, 0,  0, 0, 0, 32'hB,   0, 0, 1, H)); // overwrite
        rows.push_back(v(0, 0, 0, 32'h0,   0, 1,  0, 1, 1, 32'hB,   1, 1, 0, H));
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  0, 1, 0, 32'h0,   1, 1, 0, F));
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  0, 1, 0, 32'h0,   1, 0, 0, R));
        rows.push_back(v(0, 0, 1, 32'hC,   1, 0,  0, 1, 1, 32'hC,   1, 1, 0, R)); // branch beats halt
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  0, 1, 0, 32'h0,   1, 1, 0, F));
        rows.push_back(v(0, 0, 0, 32'h0,   0, 0,  0, 1, 0, 32'h0,   1, 0, 0, R));

        drive(1, 0, 0, 32'h0, 0, 0);
        step();
        step();

        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i].rst, rows[i].stall, rows[i].br, rows[i].tgt, rows[i].halt, rows[i].resume);
            #1;
            check($sformatf("vec%0d", i),
                  64'({pc_rst, pc_en, branch_sel, branch_val, ifid_en, ifid_flush, halted, state}),
                  64'({rows[i].prst, rows[i].pen, rows[i].bsel, rows[i].bval,
                       rows[i].ien, rows[i].ifl, rows[i].hlt, rows[i].st}));
            step();
        end

        // Single-cycle boot and single-cycle flush configuration.
        drive(1, 0, 0, 32'h0, 0, 0);
        step();
        drive(0, 0, 0, 32'h0, 0, 0);
        #1;
        check("d1_boot_state", 64'(d1_state), 64'(B));
        check("d1_boot_pc_rst", 64'(d1_pc_rst), 64'd1);
        step();
        #1;
        check("d1_run_state", 64'(d1_state), 64'(R));
        check("d1_run_pc_en", 64'(d1_pc_en), 64'd1);
        drive(0, 0, 1, 32'h900, 0, 0);
        #1;
        check("d1_br_flush", 64'({d1_branch_sel, d1_ifid_flush, d1_branch_val}), 64'({2'b11, 32'h900}));
        step();
        drive(0, 0, 0, 32'h0, 0, 0);
        #1;
        check("d1_after_br_state", 64'(d1_state), 64'(R));
        check("d1_after_br_flush", 64'(d1_ifid_flush), 64'd0);
        drive(0, 0, 0, 32'h0, 1, 0);
        step();
        drive(0, 0, 1, 32'h1234, 1, 0);
        #1;
        check("d1_halt_state", 64'({d1_state, d1_halted}), 64'({H, 1'b1}));
        step();
        drive(0, 0, 0, 32'h0, 0, 1);
        #1;
        check("d1_resume_redirect", 64'({d1_branch_sel, d1_halted, d1_branch_val}), 64'({2'b10, 32'h1234}));
        step();
        drive(0, 0, 0, 32'h0, 0, 0);
        #1;
        check("d1_resume_next_state", 64'(d1_state), 64'(R));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
